native2axil: RTL and testbench
==============================

NATIVE2AXIL -- requirements
Module: native2axil

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI and native data width; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32, AXI and native address width.
REQ-003 AXI_ACLK  input  1  sole clock; all logic on rising edge.
REQ-004 AXI_ARESET  input  1  reset, asynchronous, active-high.
REQ-005 WEN  input  1  native write request strobe, one cycle.
REQ-006 WADDR  input  ADDR_WIDTH  write address, sampled with WEN.
REQ-007 WDATA  input  DATA_WIDTH  write data, sampled with WEN.
REQ-008 WACK  output  1  one-cycle pulse: write completed on AXI.
REQ-009 REN  input  1  native read request strobe, one cycle.
REQ-010 RADDR  input  ADDR_WIDTH  read address, sampled with REN.
REQ-011 RDATA  output  DATA_WIDTH  read data, valid when RVALID high.
REQ-012 RVALID  output  1  one-cycle pulse: read data returned.
REQ-013 BUSY  output  1  high while a transaction is outstanding.
REQ-014 ERR  output  1  non-OKAY response flag (see Configuration).
REQ-015 AXI_AWADDR  output  ADDR_WIDTH  write address.
REQ-016 AXI_AWPROT  output  3  constant 3'b000.
REQ-017 AXI_AWVALID  output  1  write address valid.
REQ-018 AXI_AWREADY  input  1  write address ready.
REQ-019 AXI_WDATA  output  DATA_WIDTH  write data.
REQ-020 AXI_WSTRB  output  DATA_WIDTH/8  constant all ones.
REQ-021 AXI_WVALID  output  1  write data valid.
REQ-022 AXI_WREADY  input  1  write data ready.
REQ-023 AXI_BRESP  input  2  write response.
REQ-024 AXI_BVALID  input  1  write response valid.
REQ-025 AXI_BREADY  output  1  write response ready.
REQ-026 AXI_ARADDR  output  ADDR_WIDTH  read address.
REQ-027 AXI_ARPROT  output  3  constant 3'b000.
REQ-028 AXI_ARVALID  output  1  read address valid.
REQ-029 AXI_ARREADY  input  1  read address ready.
REQ-030 AXI_RDATA  input  DATA_WIDTH  read data.
REQ-031 AXI_RRESP  input  2  read response.
REQ-032 AXI_RVALID  input  1  read data valid.
REQ-033 AXI_RREADY  output  1  read data ready.

Function
REQ-034 Single FSM, states IDLE, WRITE, WRITE_RESP, READ, READ_RESP; at most one outstanding transaction; all outputs registered, no VALID depends combinationally on READY; BUSY high in every state except IDLE.
REQ-035 IDLE: WEN high -> latch WADDR/WDATA, next cycle AXI_AWVALID=AXI_WVALID=1, go WRITE; else REN high -> latch RADDR, next cycle AXI_ARVALID=1, go READ; WEN and REN together: write served, REN dropped; WEN/REN outside IDLE ignored.
REQ-036 WRITE: AWVALID held until AWREADY sampled high, then cleared; WVALID handled independently likewise; address/data stable while valid; when both accepted (any order, same or different cycles) go WRITE_RESP with AXI_BREADY=1.
REQ-037 WRITE_RESP: on AXI_BVALID&&AXI_BREADY clear BREADY, pulse WACK for exactly one cycle, go IDLE; minimum WEN-to-WACK latency 3 cycles with zero-wait slave.
REQ-038 READ: ARVALID held until ARREADY, then READ_RESP with AXI_RREADY=1; on AXI_RVALID&&AXI_RREADY capture AXI_RDATA into RDATA (held until next read), pulse RVALID one cycle, clear RREADY, go IDLE; minimum REN-to-RVALID latency 3 cycles.
REQ-039 A request presented in the cycle WACK or RVALID is high shall be accepted (back-to-back, no bubble beyond FSM latency).

Reset
REQ-040 AXI_ARESET high asynchronously forces state IDLE, all AXI valid/ready outputs, WACK, RVALID, BUSY, ERR to 0, address/data registers to 0; mid-transaction reset abandons the transaction with no WACK/RVALID pulse.

Configuration
REQ-041 With NATIVE2AXIL_RESP_CHECK_EN defined, ERR is set together with the WACK/RVALID pulse when BRESP/RRESP != 2'b00 and cleared when the next request is accepted; without it, ERR is constant 0 and responses are ignored.

Verification
REQ-042 Zero-wait slave, WEN with WADDR=0x10, WDATA=0xDEADBEEF -> AWADDR=0x10, WDATA=0xDEADBEEF on AXI, WACK exactly 3 cycles after WEN.
REQ-043 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles, single WACK.
REQ-044 REN RADDR=0x20, slave returns 0xCAFEF00D after 2-cycle RVALID delay -> RDATA=0xCAFEF00D, one RVALID pulse, BUSY low afterwards.
REQ-045 WEN and REN same cycle, then REN during BUSY -> one write only, no AR handshake, no RVALID.
REQ-046 AXI_ARESET during WRITE_RESP -> all outputs 0 immediately, no WACK; with macro, BRESP=2'b10 -> ERR=1 with WACK.

Source files
------------

// File: rtl/native2axil.sv
// Native single-strobe request port to AXI4-Lite master bridge, one outstanding transaction.
// Optional macro NATIVE2AXIL_RESP_CHECK_EN enables ERR reporting of non-OKAY responses.
module native2axil #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                      AXI_ACLK,
   input  logic                      AXI_ARESET,
   input  logic                      WEN,
   input  logic [ADDR_WIDTH-1:0]     WADDR,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   output logic                      WACK,
   input  logic                      REN,
   input  logic [ADDR_WIDTH-1:0]     RADDR,
   output logic [DATA_WIDTH-1:0]     RDATA,
   output logic                      RVALID,
   output logic                      BUSY,
   output logic                      ERR,
   output logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
   output logic [2:0]                AXI_AWPROT,
   output logic                      AXI_AWVALID,
   input  logic                      AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
   output logic                      AXI_WVALID,
   input  logic                      AXI_WREADY,
   input  logic [1:0]                AXI_BRESP,
   input  logic                      AXI_BVALID,
   output logic                      AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
   output logic [2:0]                AXI_ARPROT,
   output logic                      AXI_ARVALID,
   input  logic                      AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     AXI_RDATA,
   input  logic [1:0]                AXI_RRESP,
   input  logic                      AXI_RVALID,
   output logic                      AXI_RREADY
);

   typedef enum logic [2:0] {StIdle, StWrite, StWriteResp, StRead, StReadResp} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d;
   logic wack_q, wack_d, rvalid_q, rvalid_d, busy_q, busy_d, err_q, err_d;

`ifndef NATIVE2AXIL_RESP_CHECK_EN
   logic unused_resp;
   assign unused_resp = ^{AXI_BRESP, AXI_RRESP};
`endif

   always_comb begin
      state_d   = state_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      wack_d    = 1'b0;
      rvalid_d  = 1'b0;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            // Write wins when both strobes arrive together; the read is dropped.
            if (WEN) begin
               awaddr_d  = WADDR;
               wdata_d   = WDATA;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = StWrite;
`ifdef NATIVE2AXIL_RESP_CHECK_EN
               err_d     = 1'b0;
`endif
            end else if (REN) begin
               araddr_d  = RADDR;
               arvalid_d = 1'b1;
               state_d   = StRead;
`ifdef NATIVE2AXIL_RESP_CHECK_EN
               err_d     = 1'b0;
`endif
            end
         end
         StWrite: begin
            if (AXI_AWREADY) awvalid_d = 1'b0;
            if (AXI_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = StWriteResp;
            end
         end
         StWriteResp: begin
            if (AXI_BVALID && bready_q) begin
               bready_d = 1'b0;
               wack_d   = 1'b1;
               state_d  = StIdle;
`ifdef NATIVE2AXIL_RESP_CHECK_EN
               err_d    = (AXI_BRESP != 2'b00);
`endif
            end
         end
         StRead: begin
            if (AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StReadResp;
            end
         end
         StReadResp: begin
            if (AXI_RVALID && rready_q) begin
               rdata_d  = AXI_RDATA;
               rready_d = 1'b0;
               rvalid_d = 1'b1;
               state_d  = StIdle;
`ifdef NATIVE2AXIL_RESP_CHECK_EN
               err_d    = (AXI_RRESP != 2'b00);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         state_q   <= StIdle;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         wack_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         wack_q    <= wack_d;
         rvalid_q  <= rvalid_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign WACK        = wack_q;
   assign RVALID      = rvalid_q;
   assign RDATA       = rdata_q;
   assign BUSY        = busy_q;
   assign ERR         = err_q;
   assign AXI_AWADDR  = awaddr_q;
   assign AXI_AWPROT  = 3'b000;
   assign AXI_AWVALID = awvalid_q;
   assign AXI_WDATA   = wdata_q;
   assign AXI_WSTRB   = '1;
   assign AXI_WVALID  = wvalid_q;
   assign AXI_BREADY  = bready_q;
   assign AXI_ARADDR  = araddr_q;
   assign AXI_ARPROT  = 3'b000;
   assign AXI_ARVALID = arvalid_q;
   assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_native2axil.sv
// Self-checking bench for native2axil: table of single transactions against a
// delay-programmable AXI-Lite slave, plus hand-written corner-case sequences.
module tb_native2axil;

`ifdef NATIVE2AXIL_RESP_CHECK_EN
   localparam bit RESP_CHK = 1'b1;
`else
   localparam bit RESP_CHK = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1;
   logic        WEN = 1'b0, REN = 1'b0;
   logic [31:0] WADDR = '0, WDATA = '0, RADDR = '0;
   logic        WACK, RVALID, BUSY, ERR;
   logic [31:0] RDATA;
   logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
   logic [2:0]  AXI_AWPROT, AXI_ARPROT;
   logic [3:0]  AXI_WSTRB;
   logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
   logic        AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
   logic [1:0]  AXI_BRESP, AXI_RRESP;

   always #5 clk = ~clk;

   native2axil #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .AXI_ACLK(clk), .AXI_ARESET(rst),
      .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .WACK(WACK),
      .REN(REN), .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID),
      .BUSY(BUSY), .ERR(ERR),
      .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID),
      .AXI_AWREADY(AXI_AWREADY), .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
      .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY), .AXI_BRESP(AXI_BRESP),
      .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY), .AXI_ARADDR(AXI_ARADDR),
      .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
      .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
      .AXI_RREADY(AXI_RREADY)
   );

   // Slave model: each READY rises after a programmable number of VALID cycles.
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_resp = 2'b00;
   int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
   bit          aw_done, w_done, b_pend, r_pend;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign AXI_AWREADY = AXI_AWVALID && (aw_wait >= aw_dly);
   assign AXI_WREADY  = AXI_WVALID && (w_wait >= w_dly);
   assign AXI_ARREADY = AXI_ARVALID && (ar_wait >= ar_dly);
   assign AXI_BVALID  = b_pend && (b_cnt >= b_dly);
   assign AXI_RVALID  = r_pend && (r_cnt >= r_dly);
   assign AXI_RDATA   = AXI_RVALID ? s_rdata : 32'h0;
   assign AXI_BRESP   = s_resp;
   assign AXI_RRESP   = s_resp;
   assign aw_hs = AXI_AWVALID && AXI_AWREADY;
   assign w_hs  = AXI_WVALID && AXI_WREADY;
   assign b_hs  = AXI_BVALID && AXI_BREADY;
   assign ar_hs = AXI_ARVALID && AXI_ARREADY;
   assign r_hs  = AXI_RVALID && AXI_RREADY;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_done <= 0; w_done <= 0; b_pend <= 0; r_pend <= 0;
         s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0;
      end else begin
         aw_wait <= (AXI_AWVALID && !aw_hs) ? aw_wait + 1 : 0;
         w_wait  <= (AXI_WVALID && !w_hs) ? w_wait + 1 : 0;
         ar_wait <= (AXI_ARVALID && !ar_hs) ? ar_wait + 1 : 0;
         if (aw_hs) s_awaddr <= AXI_AWADDR;
         if (w_hs)  s_wdata  <= AXI_WDATA;
         if (b_pend) begin
            if (b_hs) b_pend <= 0;
            else if (!AXI_BVALID) b_cnt <= b_cnt + 1;
         end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            b_pend <= 1; b_cnt <= 0; aw_done <= 0; w_done <= 0;
         end else begin
            if (aw_hs) aw_done <= 1;
            if (w_hs)  w_done  <= 1;
         end
         if (r_pend) begin
            if (r_hs) r_pend <= 0;
            else if (!AXI_RVALID) r_cnt <= r_cnt + 1;
         end else if (ar_hs) begin
            r_pend <= 1; r_cnt <= 0; s_araddr <= AXI_ARADDR;
         end
      end
   end

   // Event counters; tests compare deltas across a window.
   int wack_cnt = 0, rv_cnt = 0, awhs_cnt = 0, arhs_cnt = 0, awv_cyc = 0, wv_cyc = 0;
   always @(posedge clk) begin
      if (WACK)        wack_cnt <= wack_cnt + 1;
      if (RVALID)      rv_cnt   <= rv_cnt + 1;
      if (aw_hs)       awhs_cnt <= awhs_cnt + 1;
      if (ar_hs)       arhs_cnt <= arhs_cnt + 1;
      if (AXI_AWVALID) awv_cyc  <= awv_cyc + 1;
      if (AXI_WVALID)  wv_cyc   <= wv_cyc + 1;
   end

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;     // write data, or slave read data / expected RDATA
      int          a_dly;    // AW or AR ready delay
      int          w_dly;
      int          rsp_dly;  // B or R valid delay
      logic [1:0]  resp;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      int lat;
      int ack0, rv0, awhs0, arhs0, awv0, wv0;
      aw_dly = v.a_dly; ar_dly = v.a_dly; w_dly = v.w_dly;
      b_dly = v.rsp_dly; r_dly = v.rsp_dly; s_rdata = v.data; s_resp = v.resp;
      ack0 = wack_cnt; rv0 = rv_cnt; awhs0 = awhs_cnt; arhs0 = arhs_cnt;
      awv0 = awv_cyc; wv0 = wv_cyc;
      @(negedge clk);
      if (v.is_wr) begin WEN = 1'b1; WADDR = v.addr; WDATA = v.data; end
      else begin REN = 1'b1; RADDR = v.addr; end
      @(posedge clk); #1;
      WEN = 1'b0; REN = 1'b0;
      lat = 1;
      check("busy_after_accept", BUSY, 1);
      check("err_clear_on_accept", ERR, 0);
      while (!(v.is_wr ? WACK : RVALID) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check(v.is_wr ? "wen_to_wack_latency" : "ren_to_rvalid_latency", lat, v.exp_lat);
      check("busy_low_at_done", BUSY, 0);
      check("err_flag", ERR, RESP_CHK && (v.resp != 2'b00));
      if (v.is_wr) begin
         check("axi_awaddr", s_awaddr, v.addr);
         check("axi_wdata", s_wdata, v.data);
      end else begin
         check("axi_araddr", s_araddr, v.addr);
         check("rdata", RDATA, v.data);
      end
      @(posedge clk); #1;
      check("done_pulse_one_cycle", v.is_wr ? WACK : RVALID, 0);
      if (v.is_wr) begin
         check("wack_count", wack_cnt - ack0, 1);
         check("aw_handshakes", awhs_cnt - awhs0, 1);
         check("no_ar_on_write", arhs_cnt - arhs0, 0);
         check("awvalid_cycles", awv_cyc - awv0, v.a_dly + 1);
         check("wvalid_cycles", wv_cyc - wv0, v.w_dly + 1);
      end else begin
         check("rvalid_count", rv_cnt - rv0, 1);
         check("ar_handshakes", arhs_cnt - arhs0, 1);
         check("no_aw_on_read", awhs_cnt - awhs0, 0);
         check("rdata_held", RDATA, v.data);
      end
   endtask

   initial begin
      int n, ack0, rv0, arhs0;
      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 3};
      vecs[1] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4, 0, 0, 2'b00, 7};
      vecs[2] = '{1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 0, 2, 1, 2'b10, 6};
      vecs[3] = '{1'b0, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, 2, 2'b00, 5};
      vecs[4] = '{1'b0, 32'h0000_0024, 32'h0BAD_C0DE, 3, 0, 0, 2'b11, 6};
      vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 3};

      repeat (3) @(posedge clk);
      #1;
      check("reset_valids_readies",
            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
      check("reset_native_flags", {WACK, RVALID, BUSY, ERR}, 0);
      check("reset_addr_data", {AXI_AWADDR, AXI_WDATA} | {AXI_ARADDR, RDATA}, 0);
      check("const_prot_strb", {AXI_AWPROT, AXI_ARPROT, AXI_WSTRB}, 10'h00F);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Simultaneous WEN/REN, then REN while busy: only the write happens.
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; s_resp = 2'b00;
      ack0 = wack_cnt; rv0 = rv_cnt; arhs0 = arhs_cnt;
      @(negedge clk);
      WEN = 1'b1; REN = 1'b1; WADDR = 32'h30; WDATA = 32'h1111_2222; RADDR = 32'h40;
      @(posedge clk); #1;
      WEN = 1'b0; REN = 1'b0;
      @(negedge clk);
      REN = 1'b1;
      @(posedge clk); #1;
      REN = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("collide_one_write", wack_cnt - ack0, 1);
      check("collide_no_ar", arhs_cnt - arhs0, 0);
      check("collide_no_rvalid", rv_cnt - rv0, 0);
      check("collide_awaddr", s_awaddr, 32'h30);

      // Read requested in the same cycle WACK is high must start immediately.
      @(negedge clk);
      WEN = 1'b1; WADDR = 32'h50; WDATA = 32'h0F0F_5A5A;
      @(posedge clk); #1;
      WEN = 1'b0;
      n = 1;
      while (!WACK && n < 40) begin @(posedge clk); #1; n++; end
      check("b2b_write_latency", n, 3);
      REN = 1'b1; RADDR = 32'h54; s_rdata = 32'h5A5A_0F0F;
      @(posedge clk); #1;
      REN = 1'b0;
      n = 1;
      while (!RVALID && n < 40) begin @(posedge clk); #1; n++; end
      check("b2b_read_latency", n, 3);
      check("b2b_rdata", RDATA, 32'h5A5A_0F0F);

      // Asynchronous reset while waiting for BVALID abandons the write.
      b_dly = 6;
      @(negedge clk);
      WEN = 1'b1; WADDR = 32'h60; WDATA = 32'h7777_8888;
      @(posedge clk); #1;
      WEN = 1'b0;
      n = 0;
      while (!AXI_BREADY && n < 40) begin @(posedge clk); #1; n++; end
      check("reached_write_resp", AXI_BREADY, 1);
      ack0 = wack_cnt;
      #2 rst = 1'b1;
      #1;
      check("async_reset_flags",
            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, WACK, BUSY, ERR}, 0);
      check("async_reset_regs", {AXI_AWADDR, AXI_WDATA}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("no_wack_after_reset", wack_cnt - ack0, 0);
      check("idle_after_reset", BUSY, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1);
   end

endmodule
